// File: rtl/stream_acc.sv
// Windowed stochastic accumulator: sums the 1s from NBIT product lanes over
// 2^IWID enabled samples and holds the total until the consumer acknowledges.
module stream_acc #(
    parameter int IWID = 8,
    parameter int NBIT = 4,
    localparam int OWID = IWID + $clog2(NBIT + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            iStart,
    input  logic            iEn,
    input  logic [NBIT-1:0] iBits,
    input  logic            iAck,
    output logic            oBusy,
    output logic            oValid,
    output logic [OWID-1:0] oSum
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state, nextState;
    logic [OWID-1:0] acc, accNext;
    logic [IWID-1:0] cnt, cntNext;
    logic [OWID-1:0] popCount;

    always_comb begin
        popCount = '0;
        for (int i = 0; i < NBIT; i++) begin
            popCount = popCount + OWID'(iBits[i]);
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    always_comb begin
        nextState = state;
        accNext   = acc;
        cntNext   = cnt;
        unique case (state)
            IDLE: begin
                if (iStart) begin
                    nextState = RUN;
                    accNext   = '0;
                    cntNext   = '0;
                end
            end
            RUN: begin
                if (iEn) begin
                    accNext = acc + popCount;
                    cntNext = cnt + IWID'(1);
                    // The all-ones count marks the last sample of the window.
                    if (&cnt) begin
                        nextState = DONE;
                    end
                end
            end
            DONE: begin
                if (iAck) begin
                    if (iStart) begin
                        nextState = RUN;
                        accNext   = '0;
                        cntNext   = '0;
                    end else begin
                        nextState = IDLE;
                    end
                end
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
        end else begin
            state <= nextState;
            acc   <= accNext;
            cnt   <= cntNext;
        end
    end

    assign oBusy  = (state == RUN);
    assign oValid = (state == DONE);
    assign oSum   = acc;

endmodule

// File: tb/tb_stream_acc.sv
// Self-checking bench for stream_acc (IWID=4, NBIT=4): directed window
// scenarios plus random traffic, all checked against a sample-counting model.
module tb_stream_acc;

    localparam int IWID = 4;
    localparam int NBIT = 4;
    localparam int OWID = IWID + $clog2(NBIT + 1);
    localparam int WIN  = 1 << IWID;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            iStart = 1'b0;
    logic            iEn = 1'b0;
    logic [NBIT-1:0] iBits = '0;
    logic            iAck = 1'b0;
    logic            oBusy;
    logic            oValid;
    logic [OWID-1:0] oSum;

    int nChecks = 0;
    int nFails  = 0;

    stream_acc #(.IWID(IWID), .NBIT(NBIT)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .iStart (iStart),
        .iEn    (iEn),
        .iBits  (iBits),
        .iAck   (iAck),
        .oBusy  (oBusy),
        .oValid (oValid),
        .oSum   (oSum)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a window is "collecting" until WIN enabled samples have
    // been seen, then the total is "ready" until an acknowledge takes it away.
    logic mCollecting, mReady;
    int   mSeen, mTotal;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mCollecting <= 1'b0;
            mReady      <= 1'b0;
            mSeen       <= 0;
            mTotal      <= 0;
        end else if (mReady) begin
            if (iAck) begin
                mReady <= 1'b0;
                if (iStart) begin
                    mCollecting <= 1'b1;
                    mSeen       <= 0;
                    mTotal      <= 0;
                end
            end
        end else if (mCollecting) begin
            if (iEn) begin
                mTotal <= mTotal + $countones(iBits);
                mSeen  <= mSeen + 1;
                if (mSeen + 1 == WIN) begin
                    mCollecting <= 1'b0;
                    mReady      <= 1'b1;
                end
            end
        end else if (iStart) begin
            mCollecting <= 1'b1;
            mSeen       <= 0;
            mTotal      <= 0;
        end
    end

    always @(negedge clk) begin
        check("model_busy", int'(oBusy), int'(mCollecting));
        check("model_valid", int'(oValid), int'(mReady));
        check("model_sum", int'(oSum), mTotal);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        iStart = 1'b0;
        iEn    = 1'b0;
        iBits  = '0;
        iAck   = 1'b0;
    endtask

    task automatic startWindow();
        iStart = 1'b1;
        tick();
        iStart = 1'b0;
    endtask

    task automatic feed(input logic [NBIT-1:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            iEn   = 1'b1;
            iBits = bits;
            tick();
        end
        iEn   = 1'b0;
        iBits = '0;
    endtask

    task automatic ackResult();
        iAck = 1'b1;
        tick();
        iAck = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int expSum;
        logic [NBIT-1:0] b;

        idleInputs();
        repeat (3) @(negedge clk);
        check("reset_busy", int'(oBusy), 0);
        check("reset_valid", int'(oValid), 0);
        check("reset_sum", int'(oSum), 0);
        rst_n = 1'b1;

        // Full window of all-ones lanes.
        startWindow();
        feed(4'b1111, WIN);
        @(negedge clk);
        check("ones_valid", int'(oValid), 1);
        check("ones_busy", int'(oBusy), 0);
        check("ones_sum", int'(oSum), 64);
        ackResult();

        // Alternating bits with five stalled cycles: valid arrives 5 cycles late.
        startWindow();
        for (int c = 0, s = 0; c < WIN + 5; c++) begin
            iEn = !(c == 2 || c == 5 || c == 9 || c == 13 || c == 17);
            iBits = (s % 2 == 0) ? 4'b0101 : 4'b0000;
            if (iEn) s++;
            if (c == WIN + 3) begin
                @(negedge clk);
                check("stall_not_early", int'(oValid), 0);
            end
            tick();
        end
        idleInputs();
        @(negedge clk);
        check("stall_valid", int'(oValid), 1);
        check("stall_sum", int'(oSum), 16);

        // Result held while the consumer stalls.
        for (int i = 0; i < 10; i++) begin
            iStart = (i == 4);
            tick();
            check("hold_valid", int'(oValid), 1);
            check("hold_sum", int'(oSum), 16);
        end
        iStart = 1'b0;
        ackResult();
        check("ack_valid", int'(oValid), 0);
        check("ack_busy", int'(oBusy), 0);

        // Back-to-back windows: start with ack, then an all-zero window.
        startWindow();
        feed(4'b1111, WIN);
        iStart = 1'b1;
        iAck   = 1'b1;
        tick();
        idleInputs();
        check("b2b_busy", int'(oBusy), 1);
        check("b2b_clear", int'(oSum), 0);
        feed(4'b0000, WIN);
        check("zero_valid", int'(oValid), 1);
        check("zero_sum", int'(oSum), 0);
        ackResult();

        // iStart re-pulsed mid-window is ignored.
        startWindow();
        expSum = 0;
        for (int s = 0; s < WIN; s++) begin
            b      = NBIT'($urandom);
            expSum += $countones(b);
            iStart = (s == 7);
            feed(b, 1);
        end
        iStart = 1'b0;
        check("restart_ignored_sum", int'(oSum), expSum);
        check("restart_ignored_valid", int'(oValid), 1);
        ackResult();

        // Asynchronous reset mid-window.
        startWindow();
        feed(4'b1011, 8);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_busy", int'(oBusy), 0);
        check("async_valid", int'(oValid), 0);
        check("async_sum", int'(oSum), 0);
        @(negedge clk);
        rst_n = 1'b1;
        feed(4'b1111, 5);
        check("after_reset_idle", int'(oBusy), 0);
        check("after_reset_sum", int'(oSum), 0);

        // iStart at the very first edge after reset release is accepted.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n  = 1'b1;
        iStart = 1'b1;
        tick();
        iStart = 1'b0;
        check("first_edge_start", int'(oBusy), 1);

        // Random traffic, checked every cycle by the model.
        for (int i = 0; i < 600; i++) begin
            iStart = ($urandom_range(7) == 0);
            iEn    = ($urandom_range(3) != 0);
            iBits  = NBIT'($urandom);
            iAck   = ($urandom_range(3) == 0);
            tick();
        end
        idleInputs();
        @(negedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/stream_acc.md
STREAM_ACC -- requirements
Module: stream_acc

Interface
REQ-001 SHALL have parameter IWID, default 8: window length is 2^IWID enabled samples.
REQ-002 SHALL have parameter NBIT, default 4: number of parallel stochastic bit lanes.
REQ-003 SHALL derive OWID = IWID + $clog2(NBIT+1) as the result width; it is not overridable.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port iStart, input, 1 bit: request to open a new accumulation window.
REQ-007 SHALL have port iEn, input, 1 bit: the current iBits are a valid sample.
REQ-008 SHALL have port iBits, input, NBIT bits: the product bits from the upstream multiplier lanes.
REQ-009 SHALL have port iAck, input, 1 bit: the consumer accepts oSum.
REQ-010 SHALL have port oBusy, output, 1 bit: a window is in progress.
REQ-011 SHALL have port oValid, output, 1 bit: oSum holds a completed result.
REQ-012 SHALL have port oSum, output, OWID bits: the total count of 1s over the window, all lanes.

Function
REQ-013 SHALL implement a 3-state FSM with states IDLE, RUN and DONE.
REQ-014 SHALL, in IDLE with iStart=1, clear the accumulator and the window counter at the edge and enter RUN; iBits in the iStart cycle are not counted.
REQ-015 SHALL, in RUN with iEn=1, add popcount(iBits) (range 0..NBIT) to the accumulator and increment the IWID-bit window counter at each edge.
REQ-016 SHALL, in RUN with iEn=0, hold both the accumulator and the window counter.
REQ-017 SHALL, at the edge that consumes the 2^IWID-th enabled sample (counter wraps from all-ones to 0), include that sample and enter DONE.
REQ-018 SHALL make oValid=1 in the cycle after that final edge, so latency from the last sample to oValid is 1 cycle.
REQ-019 SHALL hold oSum stable while in DONE.
REQ-020 SHALL keep oValid=1 in DONE until iAck=1 is sampled; iAck then returns the FSM to IDLE and oValid falls at that edge.
REQ-021 SHALL, in DONE with iStart=1 and iAck=1 in the same cycle, go directly to RUN with the accumulator cleared (back-to-back windows, no idle cycle).
REQ-022 SHALL, in DONE with iStart=1 and iAck=0, ignore iStart.
REQ-023 SHALL ignore iStart while in RUN; the window in progress is not restarted.
REQ-024 SHALL ignore iAck in IDLE and RUN.
REQ-025 SHALL ignore iEn outside RUN.
REQ-026 SHALL size the accumulator so that no overflow can occur: maximum value NBIT*2^IWID fits in OWID bits, and no saturation logic is needed.
REQ-027 SHALL drive oBusy=1 exactly when the FSM is in RUN.
REQ-028 SHALL drive oValid=1 exactly when the FSM is in DONE.
REQ-029 SHALL let oSum show the running accumulator during RUN; it has meaning only when oValid=1.

Reset
REQ-030 SHALL, on rst_n=0, immediately (asynchronously) force FSM=IDLE, accumulator=0, window counter=0, oBusy=0, oValid=0 and oSum=0.
REQ-031 SHALL abort any window when reset is asserted mid-RUN or mid-DONE; no partial result is presented after rst_n rises.
REQ-032 SHALL, after rst_n rises, treat the first rising edge like any other edge; iStart sampled at that edge is accepted.

Verification (IWID=4, NBIT=4; window = 16 samples)
REQ-033 SHALL cover: iStart pulse, then iEn=1 and iBits=4'b1111 for 16 cycles -> oValid rises 1 cycle after the 16th sample with oSum=64; oBusy is low in the same cycle.
REQ-034 SHALL cover: iBits alternating 4'b0101 / 4'b0000 over 16 samples, with iEn=0 on 5 interleaved cycles -> oSum=16 and oValid is delayed exactly 5 cycles.
REQ-035 SHALL cover: iAck held 0 for 10 cycles in DONE -> oValid and oSum stay stable; iAck=1 -> IDLE next cycle with oValid=0.
REQ-036 SHALL cover: iStart and iAck together in DONE -> oBusy=1 next cycle and a second window of all-zero bits yields oSum=0.
REQ-037 SHALL cover: iStart re-pulsed at sample 8 of RUN -> ignored, result unchanged; rst_n pulsed low at sample 8 of another window -> outputs 0 immediately, stays IDLE without a new iStart.
REQ-038 SHALL cover: all-zero iBits for a full window -> oSum=0 with oValid=1.
